ioctl_rom_loader: RTL

- Parametrised successor to the single-ROM download path in the tiamc1 top: turns the HPS ioctl byte stream into DATA_W-wide writes across REGIONS ROM/RAM regions.
- Packs bytes little-endian into words, stalls the HPS through ioctl_wait while a word is pending, and flushes a partial trailing word with byte enables.
- Reports per-region load status, a running checksum and a completion pulse.
- Sits between hps_io and the core's ROM blocks, clocked on clk_sys.

---
 rtl/ioctl_rom_loader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ioctl_rom_loader.sv
// rtl/ioctl_rom_loader.sv - packs hps_io ioctl bytes into word writes across ROM/RAM regions
module ioctl_rom_loader #(
    parameter int DATA_W    = 16,
    parameter int REGIONS   = 4,
    parameter int REGION_AW = 14,
    parameter int ROM_INDEX = 0,
    localparam int BW  = DATA_W / 8,
    localparam int LB  = $clog2(BW),
    localparam int RW  = (REGIONS > 1) ? $clog2(REGIONS) : 1,
    localparam int WAW = REGION_AW - LB
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_data,
    output logic                 ioctl_wait,
    output logic                 wr_req,
    output logic [RW-1:0]        wr_region,
    output logic [WAW-1:0]       wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic [BW-1:0]        wr_be,
    input  logic                 wr_ack,
    output logic                 loading,
    output logic                 done,
    output logic [REGIONS-1:0]   region_loaded,
    output logic                 overflow,
    output logic [15:0]          checksum
);

    // byte address width covering all regions, and the matching word index width
    localparam int TAW = REGION_AW + $clog2(REGIONS);
    localparam int WIW = TAW - LB;
    localparam logic [31:0] LIMIT = 32'(REGIONS) << REGION_AW;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_FINISH} state_t;

    state_t              state_q, state_d;
    logic                dl_q;
    logic [DATA_W-1:0]   pack_data_q, pack_data_d;
    logic [BW-1:0]       pack_be_q, pack_be_d;
    logic [WIW-1:0]      pack_widx_q, pack_widx_d;
    logic                skid_valid_q, skid_valid_d;
    logic [TAW-1:0]      skid_addr_q, skid_addr_d;
    logic [7:0]          skid_data_q, skid_data_d;
    logic                fall_q, fall_d;
    logic [REGIONS-1:0]  region_loaded_d;
    logic                overflow_d;
    logic [15:0]         checksum_d;

    logic                strobe, in_range, fall_now, ended, pack_empty, use_src;
    logic [TAW-1:0]      src_addr;
    logic [7:0]          src_data;
    logic [31:0]         src_lane;
    logic [WIW-1:0]      src_widx;

    assign ioctl_wait = (state_q == S_FLUSH) | skid_valid_q;
    assign wr_req     = (state_q == S_FLUSH);
    assign loading    = (state_q == S_COLLECT) | (state_q == S_FLUSH);
    assign done       = (state_q == S_FINISH);
    assign wr_region  = RW'(pack_widx_q >> WAW);
    assign wr_addr    = pack_widx_q[WAW-1:0];
    assign wr_data    = pack_data_q;
    assign wr_be      = pack_be_q;

    // state and datapath registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            dl_q          <= 1'b0;
            pack_data_q   <= '0;
            pack_be_q     <= '0;
            pack_widx_q   <= '0;
            skid_valid_q  <= 1'b0;
            skid_addr_q   <= '0;
            skid_data_q   <= '0;
            fall_q        <= 1'b0;
            region_loaded <= '0;
            overflow      <= 1'b0;
            checksum      <= '0;
        end else begin
            state_q       <= state_d;
            dl_q          <= ioctl_download;
            pack_data_q   <= pack_data_d;
            pack_be_q     <= pack_be_d;
            pack_widx_q   <= pack_widx_d;
            skid_valid_q  <= skid_valid_d;
            skid_addr_q   <= skid_addr_d;
            skid_data_q   <= skid_data_d;
            fall_q        <= fall_d;
            region_loaded <= region_loaded_d;
            overflow      <= overflow_d;
            checksum      <= checksum_d;
        end
    end

    // next-state: byte packing, skid capture, flush handshake and download end
    always_comb begin
        state_d         = state_q;
        pack_data_d     = pack_data_q;
        pack_be_d       = pack_be_q;
        pack_widx_d     = pack_widx_q;
        skid_valid_d    = skid_valid_q;
        skid_addr_d     = skid_addr_q;
        skid_data_d     = skid_data_q;
        fall_d          = fall_q;
        region_loaded_d = region_loaded;
        overflow_d      = overflow;
        checksum_d      = checksum;
        use_src         = 1'b0;

        strobe     = ioctl_wr & ioctl_download;
        in_range   = {7'd0, ioctl_addr} < LIMIT;
        fall_now   = dl_q & ~ioctl_download;
        ended      = fall_q | fall_now;
        pack_empty = (pack_be_q == '0);

        // a held skid byte always goes ahead of any new strobe
        src_addr = skid_valid_q ? skid_addr_q : ioctl_addr[TAW-1:0];
        src_data = skid_valid_q ? skid_data_q : ioctl_data;
        src_lane = 32'(src_addr) % 32'(BW);
        src_widx = WIW'(32'(src_addr) / 32'(BW));

        case (state_q)
            S_IDLE: begin
                if (ioctl_download && !dl_q && ioctl_index == 8'(ROM_INDEX)) begin
                    state_d         = S_COLLECT;
                    region_loaded_d = '0;
                    overflow_d      = 1'b0;
                    checksum_d      = '0;
                    fall_d          = 1'b0;
                    pack_be_d       = '0;
                    pack_data_d     = '0;
                    skid_valid_d    = 1'b0;
                end
            end
            S_COLLECT: begin
                if (fall_now) fall_d = 1'b1;
                if (skid_valid_q) begin
                    use_src = 1'b1;
                    if (strobe) overflow_d = 1'b1;
                end else if (ended) begin
                    fall_d  = 1'b1;
                    state_d = pack_empty ? S_FINISH : S_FLUSH;
                end else if (strobe) begin
                    if (!in_range) begin
                        overflow_d = 1'b1;
                    end else begin
                        use_src    = 1'b1;
                        checksum_d = checksum + 16'(ioctl_data);
                    end
                end
            end
            S_FLUSH: begin
                if (fall_now) fall_d = 1'b1;
                if (strobe) begin
                    if (!in_range || skid_valid_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_addr_d  = ioctl_addr[TAW-1:0];
                        skid_data_d  = ioctl_data;
                        checksum_d   = checksum + 16'(ioctl_data);
                    end
                end
                if (wr_ack) begin
                    pack_be_d   = '0;
                    pack_data_d = '0;
                    for (int r = 0; r < REGIONS; r++)
                        if (wr_region == RW'(r)) region_loaded_d[r] = 1'b1;
                    state_d = (!skid_valid_d && ended) ? S_FINISH : S_COLLECT;
                end
            end
            S_FINISH: begin
                fall_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // place the selected byte: new word while packing parks it in the skid
        if (use_src) begin
            if (!pack_empty && src_widx != pack_widx_q) begin
                skid_valid_d = 1'b1;
                skid_addr_d  = src_addr;
                skid_data_d  = src_data;
                state_d      = S_FLUSH;
            end else begin
                skid_valid_d = 1'b0;
                pack_widx_d  = src_widx;
                for (int i = 0; i < BW; i++) begin
                    if (src_lane == 32'(i)) begin
                        pack_data_d[i*8 +: 8] = src_data;
                        pack_be_d[i]          = 1'b1;
                    end
                end
                if (src_lane == 32'(BW - 1)) state_d = S_FLUSH;
            end
        end
    end

endmodule
